// File: rtl/core_lsu_ctrl_if.sv
// ----------------------------------------------------------------------------
// core_lsu_ctrl_if
// Signal bundle between the memory stage / L1D cache and core_lsu_ctrl.
//   lsu_*_in   : memory-stage operation (req, we, size, addr, wdata, kill)
//   l1d_*_in   : L1D completion (ack, read word)
//   l1d_*_out  : L1D request (req, we, word addr, byte enables, store data)
//   lsu_*_out  : results to the pipeline (rdata, vld, stall, misalign, err)
// modport slave  : view taken by core_lsu_ctrl
// modport master : view taken by the surrounding pipeline / cache model
// ----------------------------------------------------------------------------
interface core_lsu_ctrl_if;
   logic        lsu_req_in;
   logic        lsu_we_in;
   logic [1:0]  lsu_size_in;
   logic [31:0] lsu_addr_in;
   logic [31:0] lsu_wdata_in;
   logic        lsu_kill_in;
   logic        l1d_ack_in;
   logic [31:0] l1d_rdata_in;
   logic        l1d_req_out;
   logic        l1d_we_out;
   logic [31:0] l1d_addr_out;
   logic [3:0]  l1d_be_out;
   logic [31:0] l1d_wdata_out;
   logic [31:0] lsu_rdata_out;
   logic        lsu_rdata_vld_out;
   logic        lsu_stall_out;
   logic        lsu_misalign_out;
   logic        lsu_err_out;

   modport slave (
      input  lsu_req_in, lsu_we_in, lsu_size_in, lsu_addr_in, lsu_wdata_in,
             lsu_kill_in, l1d_ack_in, l1d_rdata_in,
      output l1d_req_out, l1d_we_out, l1d_addr_out, l1d_be_out, l1d_wdata_out,
             lsu_rdata_out, lsu_rdata_vld_out, lsu_stall_out, lsu_misalign_out,
             lsu_err_out
   );

   modport master (
      output lsu_req_in, lsu_we_in, lsu_size_in, lsu_addr_in, lsu_wdata_in,
             lsu_kill_in, l1d_ack_in, l1d_rdata_in,
      input  l1d_req_out, l1d_we_out, l1d_addr_out, l1d_be_out, l1d_wdata_out,
             lsu_rdata_out, lsu_rdata_vld_out, lsu_stall_out, lsu_misalign_out,
             lsu_err_out
   );
endinterface

// File: rtl/core_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// core_lsu_ctrl
// Load/store sequencer between the memory stage and the L1 data cache.
// Accepts one operation at a time, holds the pipeline until the L1D acks
// (or the access times out), and returns load data LSB-aligned.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : core_lsu_ctrl_if.slave, all operation / L1D / result signals
// Parameter TIMEOUT (1..255): BUSY cycles without ack before a bus error.
// ----------------------------------------------------------------------------
module core_lsu_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   core_lsu_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counter value seen in the last BUSY cycle before a timeout.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   be_of = 4'b0001 << off;
         2'b01:   be_of = 4'b0011 << off;
         default: be_of = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] repl_of(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   repl_of = {4{d[7:0]}};
         2'b01:   repl_of = {2{d[15:0]}};
         default: repl_of = d;
      endcase
   endfunction

   logic [1:0]  state;
   logic [7:0]  cnt;
   logic        kill_q;
   logic        we_q;
   logic [29:0] waddr_q;
   logic [1:0]  off_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic misaligned;
   logic accept;
   logic killed;

   assign misaligned = ((bus.lsu_size_in == 2'b01) && bus.lsu_addr_in[0]) ||
                       (bus.lsu_size_in[1] && (bus.lsu_addr_in[1:0] != 2'b00));
   assign accept     = (state == ST_IDLE) && bus.lsu_req_in && !misaligned && !bus.lsu_kill_in;
   // A flush in the completing cycle counts the same as an earlier one.
   assign killed     = kill_q || bus.lsu_kill_in;

   assign bus.l1d_req_out       = (state == ST_BUSY);
   assign bus.l1d_we_out        = we_q;
   assign bus.l1d_addr_out      = {waddr_q, 2'b00};
   assign bus.l1d_be_out        = be_q;
   assign bus.l1d_wdata_out     = wdata_q;
   assign bus.lsu_rdata_out     = rdata_q;
   assign bus.lsu_rdata_vld_out = (state == ST_DONE);
   assign bus.lsu_err_out       = err_q;
   assign bus.lsu_stall_out     = accept || (state == ST_BUSY);
   assign bus.lsu_misalign_out  = (state == ST_IDLE) && bus.lsu_req_in && misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= 8'd0;
         kill_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= 30'd0;
         off_q   <= 2'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q    <= bus.lsu_we_in;
                  waddr_q <= bus.lsu_addr_in[31:2];
                  off_q   <= bus.lsu_addr_in[1:0];
                  be_q    <= be_of(bus.lsu_size_in, bus.lsu_addr_in[1:0]);
                  wdata_q <= repl_of(bus.lsu_size_in, bus.lsu_wdata_in);
                  cnt     <= 8'd0;
                  kill_q  <= 1'b0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (bus.l1d_ack_in) begin
                  cnt    <= 8'd0;
                  kill_q <= 1'b0;
                  if (killed) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_DONE;
                     if (!we_q) rdata_q <= bus.l1d_rdata_in >> {off_q, 3'b000};
                  end
               end else if (cnt == CNT_LAST) begin
                  cnt    <= 8'd0;
                  kill_q <= 1'b0;
                  if (killed) begin
                     state <= ST_IDLE;
                  end else begin
                     state   <= ST_DONE;
                     err_q   <= 1'b1;
                     rdata_q <= 32'd0;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
                  if (bus.lsu_kill_in) kill_q <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
module tb_core_lsu_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   core_lsu_ctrl_if a ();
   core_lsu_ctrl_if b ();

   core_lsu_ctrl #(.TIMEOUT(255)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
   core_lsu_ctrl #(.TIMEOUT(4))   u_b (.clk(clk), .rst_n(rst_n), .bus(b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the start of the next cycle (1 time unit after the edge).
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic op_a(input logic req, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
      a.lsu_req_in   = req;
      a.lsu_we_in    = we;
      a.lsu_size_in  = size;
      a.lsu_addr_in  = addr;
      a.lsu_wdata_in = wdata;
   endtask

   initial begin
      a.lsu_req_in = 0; a.lsu_we_in = 0; a.lsu_size_in = 0; a.lsu_addr_in = 0;
      a.lsu_wdata_in = 0; a.lsu_kill_in = 0; a.l1d_ack_in = 0; a.l1d_rdata_in = 0;
      b.lsu_req_in = 0; b.lsu_we_in = 0; b.lsu_size_in = 0; b.lsu_addr_in = 0;
      b.lsu_wdata_in = 0; b.lsu_kill_in = 0; b.l1d_ack_in = 0; b.l1d_rdata_in = 0;

      // reset state
      next_cycle();
      settle();
      chk("rst_req",   32'(a.l1d_req_out), 32'd0);
      chk("rst_vld",   32'(a.lsu_rdata_vld_out), 32'd0);
      chk("rst_stall", 32'(a.lsu_stall_out), 32'd0);
      chk("rst_err",   32'(a.lsu_err_out), 32'd0);
      chk("rst_rdata", a.lsu_rdata_out, 32'd0);
      chk("rst_addr",  a.l1d_addr_out, 32'd0);
      chk("rst_be",    32'(a.l1d_be_out), 32'd0);
      next_cycle();
      rst_n = 1'b1;

      // word load at 0x100, ack in cycle 3
      next_cycle();
      op_a(1, 0, 2'b10, 32'h100, 32'h0);
      settle();
      chk("wl_c0_stall", 32'(a.lsu_stall_out), 32'd1);
      chk("wl_c0_req",   32'(a.l1d_req_out), 32'd0);
      next_cycle();
      settle();
      chk("wl_c1_req",  32'(a.l1d_req_out), 32'd1);
      chk("wl_c1_addr", a.l1d_addr_out, 32'h100);
      chk("wl_c1_be",   32'(a.l1d_be_out), 32'hF);
      chk("wl_c1_we",   32'(a.l1d_we_out), 32'd0);
      next_cycle();
      settle();
      chk("wl_c2_req",   32'(a.l1d_req_out), 32'd1);
      chk("wl_c2_stall", 32'(a.lsu_stall_out), 32'd1);
      next_cycle();
      a.l1d_ack_in = 1; a.l1d_rdata_in = 32'hDEADBEEF;
      settle();
      chk("wl_c3_req",   32'(a.l1d_req_out), 32'd1);
      chk("wl_c3_stall", 32'(a.lsu_stall_out), 32'd1);
      chk("wl_c3_vld",   32'(a.lsu_rdata_vld_out), 32'd0);
      next_cycle();
      a.l1d_ack_in = 0; a.l1d_rdata_in = 0;
      settle();
      chk("wl_c4_vld",   32'(a.lsu_rdata_vld_out), 32'd1);
      chk("wl_c4_rdata", a.lsu_rdata_out, 32'hDEADBEEF);
      chk("wl_c4_stall", 32'(a.lsu_stall_out), 32'd0);
      chk("wl_c4_req",   32'(a.l1d_req_out), 32'd0);
      next_cycle();
      op_a(0, 0, 2'b00, 32'h0, 32'h0);
      settle();
      chk("wl_c5_vld",   32'(a.lsu_rdata_vld_out), 32'd0);
      chk("wl_c5_req",   32'(a.l1d_req_out), 32'd0);
      chk("wl_c5_hold",  a.lsu_rdata_out, 32'hDEADBEEF);

      // byte store of 0xA5 at 0x203, ack in cycle 1
      next_cycle();
      op_a(1, 1, 2'b00, 32'h203, 32'h123456A5);
      next_cycle();
      a.l1d_ack_in = 1;
      settle();
      chk("bs_addr",  a.l1d_addr_out, 32'h200);
      chk("bs_be",    32'(a.l1d_be_out), 32'h8);
      chk("bs_wdata", a.l1d_wdata_out, 32'hA5A5A5A5);
      chk("bs_we",    32'(a.l1d_we_out), 32'd1);
      next_cycle();
      a.l1d_ack_in = 0;
      settle();
      chk("bs_vld",   32'(a.lsu_rdata_vld_out), 32'd1);
      chk("bs_rdata_kept", a.lsu_rdata_out, 32'hDEADBEEF);
      next_cycle();
      op_a(0, 0, 2'b00, 32'h0, 32'h0);

      // half store replication
      next_cycle();
      op_a(1, 1, 2'b01, 32'h12, 32'hFFFFBEEF);
      next_cycle();
      a.l1d_ack_in = 1;
      settle();
      chk("hs_wdata", a.l1d_wdata_out, 32'hBEEFBEEF);
      chk("hs_be",    32'(a.l1d_be_out), 32'hC);
      next_cycle();
      a.l1d_ack_in = 0;
      next_cycle();
      op_a(0, 0, 2'b00, 32'h0, 32'h0);

      // half load at 0x42
      next_cycle();
      op_a(1, 0, 2'b01, 32'h42, 32'h0);
      next_cycle();
      a.l1d_ack_in = 1; a.l1d_rdata_in = 32'h12345678;
      settle();
      chk("hl_be",   32'(a.l1d_be_out), 32'hC);
      chk("hl_addr", a.l1d_addr_out, 32'h40);
      next_cycle();
      a.l1d_ack_in = 0; a.l1d_rdata_in = 0;
      settle();
      chk("hl_vld",   32'(a.lsu_rdata_vld_out), 32'd1);
      chk("hl_rdata", a.lsu_rdata_out, 32'h00001234);
      next_cycle();
      op_a(0, 0, 2'b00, 32'h0, 32'h0);

      // misaligned half at 0x41 and word at 0x102
      next_cycle();
      op_a(1, 0, 2'b01, 32'h41, 32'h0);
      settle();
      chk("mis_h_flag",  32'(a.lsu_misalign_out), 32'd1);
      chk("mis_h_stall", 32'(a.lsu_stall_out), 32'd0);
      next_cycle();
      settle();
      chk("mis_h_req",   32'(a.l1d_req_out), 32'd0);
      op_a(1, 0, 2'b10, 32'h102, 32'h0);
      settle();
      chk("mis_w_flag",  32'(a.lsu_misalign_out), 32'd1);
      op_a(1, 0, 2'b00, 32'h103, 32'h0);
      settle();
      chk("byte_no_mis", 32'(a.lsu_misalign_out), 32'd0);
      op_a(0, 0, 2'b00, 32'h0, 32'h0);

      // kill in cycle 2 of a load, ack in cycle 5
      next_cycle();
      op_a(1, 0, 2'b10, 32'h300, 32'h0);
      next_cycle();
      settle();
      chk("kl_c1_req", 32'(a.l1d_req_out), 32'd1);
      next_cycle();
      a.lsu_kill_in = 1;
      settle();
      chk("kl_c2_stall", 32'(a.lsu_stall_out), 32'd1);
      next_cycle();
      a.lsu_kill_in = 0;
      op_a(0, 0, 2'b00, 32'h0, 32'h0);
      next_cycle();
      settle();
      chk("kl_c4_stall", 32'(a.lsu_stall_out), 32'd1);
      next_cycle();
      a.l1d_ack_in = 1; a.l1d_rdata_in = 32'h55;
      settle();
      chk("kl_c5_stall", 32'(a.lsu_stall_out), 32'd1);
      chk("kl_c5_req",   32'(a.l1d_req_out), 32'd1);
      next_cycle();
      a.l1d_ack_in = 0; a.l1d_rdata_in = 0;
      op_a(1, 0, 2'b10, 32'h400, 32'h0);
      settle();
      chk("kl_c6_vld",   32'(a.lsu_rdata_vld_out), 32'd0);
      chk("kl_c6_err",   32'(a.lsu_err_out), 32'd0);
      chk("kl_c6_stall", 32'(a.lsu_stall_out), 32'd1);
      chk("kl_c6_rdata", a.lsu_rdata_out, 32'h00001234);
      next_cycle();
      a.l1d_ack_in = 1; a.l1d_rdata_in = 32'h0BADF00D;
      settle();
      chk("kl_c7_addr", a.l1d_addr_out, 32'h400);
      next_cycle();
      a.l1d_ack_in = 0; a.l1d_rdata_in = 0;
      settle();
      chk("kl_c8_vld",   32'(a.lsu_rdata_vld_out), 32'd1);
      chk("kl_c8_rdata", a.lsu_rdata_out, 32'h0BADF00D);
      next_cycle();
      op_a(0, 0, 2'b00, 32'h0, 32'h0);

      // kill together with the request in cycle 0
      next_cycle();
      op_a(1, 0, 2'b10, 32'h500, 32'h0);
      a.lsu_kill_in = 1;
      settle();
      chk("k0_stall", 32'(a.lsu_stall_out), 32'd0);
      next_cycle();
      a.lsu_kill_in = 0;
      op_a(0, 0, 2'b00, 32'h0, 32'h0);
      settle();
      chk("k0_req", 32'(a.l1d_req_out), 32'd0);

      // timeout on the TIMEOUT=4 instance, after one good load on it
      next_cycle();
      b.lsu_req_in = 1; b.lsu_size_in = 2'b10; b.lsu_addr_in = 32'h600;
      next_cycle();
      b.l1d_ack_in = 1; b.l1d_rdata_in = 32'hCAFEF00D;
      next_cycle();
      b.l1d_ack_in = 0; b.l1d_rdata_in = 0;
      settle();
      chk("to_pre_rdata", b.lsu_rdata_out, 32'hCAFEF00D);
      next_cycle();
      b.lsu_req_in = 0;
      next_cycle();
      b.lsu_req_in = 1;
      next_cycle();
      settle();
      chk("to_c1_req", 32'(b.l1d_req_out), 32'd1);
      next_cycle();
      next_cycle();
      next_cycle();
      settle();
      chk("to_c4_req", 32'(b.l1d_req_out), 32'd1);
      chk("to_c4_err", 32'(b.lsu_err_out), 32'd0);
      next_cycle();
      settle();
      chk("to_c5_err",   32'(b.lsu_err_out), 32'd1);
      chk("to_c5_vld",   32'(b.lsu_rdata_vld_out), 32'd1);
      chk("to_c5_req",   32'(b.l1d_req_out), 32'd0);
      chk("to_c5_rdata", b.lsu_rdata_out, 32'd0);
      next_cycle();
      b.lsu_req_in = 0;
      settle();
      chk("to_c6_err",   32'(b.lsu_err_out), 32'd0);
      chk("to_c6_vld",   32'(b.lsu_rdata_vld_out), 32'd0);
      chk("to_c6_req",   32'(b.l1d_req_out), 32'd0);

      // reset in cycle 2 of BUSY
      next_cycle();
      op_a(1, 0, 2'b10, 32'h700, 32'h0);
      next_cycle();
      next_cycle();
      settle();
      chk("rb_pre_req", 32'(a.l1d_req_out), 32'd1);
      op_a(0, 0, 2'b00, 32'h0, 32'h0);
      rst_n = 1'b0;
      settle();
      chk("rb_req",   32'(a.l1d_req_out), 32'd0);
      chk("rb_stall", 32'(a.lsu_stall_out), 32'd0);
      chk("rb_addr",  a.l1d_addr_out, 32'd0);
      chk("rb_rdata", a.lsu_rdata_out, 32'd0);
      chk("rb_be",    32'(a.l1d_be_out), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      a.l1d_ack_in = 1; a.l1d_rdata_in = 32'h77777777;
      next_cycle();
      a.l1d_ack_in = 0; a.l1d_rdata_in = 0;
      settle();
      chk("rb_late_vld",   32'(a.lsu_rdata_vld_out), 32'd0);
      chk("rb_late_rdata", a.lsu_rdata_out, 32'd0);
      next_cycle();
      settle();
      chk("rb_late_vld2",  32'(a.lsu_rdata_vld_out), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
